pipelined_ripple_adder: RTL

//  - Parametrised N-bit adder/subtractor, bit-level pipelined. Successor to the single-bit two-stage clocked full adder.
//  - Each bit is one two-stage clocked full-adder cell. Carry ripples one cell per 2 cycles.
//  - Input skew and output deskew DFF chains keep all bits of one operand set aligned.
//  - Throughput: 1 operation per clock. No stalls; the pipeline cannot be back-pressured.
//  - Used as the arithmetic datapath feeding the accumulator/ALU blocks of the benchmark suite.

---
 rtl/pipelined_ripple_adder_pkg.sv | 7 +
 rtl/fa_pipe_cell.sv | 21 ++
 rtl/pipelined_ripple_adder.sv | 74 +++++++
 3 files changed

// File: rtl/pipelined_ripple_adder_pkg.sv
// pipelined_ripple_adder_pkg: cell stage count and latency formula shared by the arithmetic blocks
package pipelined_ripple_adder_pkg;
  localparam int CELL_STAGES = 2;
  function automatic int adder_lat(input int width);
    return CELL_STAGES * width;
  endfunction
endpackage

// File: rtl/fa_pipe_cell.sv
// fa_pipe_cell: one bit of the ripple adder as a two-stage clocked full adder
module fa_pipe_cell (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  logic r_x, r_g, r_c;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_x, r_g, r_c, s, c_out} <= '0;
    else begin
      r_x   <= a ^ b;
      r_g   <= a & b;
      r_c   <= c_in;
      s     <= r_x ^ r_c;
      c_out <= r_g | (r_x & r_c);
    end
endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: bit-level pipelined adder/subtractor, one cell per bit,
// operands skewed in and sums deskewed out so each operand set stays aligned
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LAT = adder_lat(WIDTH);
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_c;
  logic [LAT-1:0]   r_v;
  logic [1:0]       r_cm;
  // b is inverted before skewing, so the delayed sub bit is folded into the operand
  assign w_b    = b ^ {WIDTH{sub}};
  assign w_c[0] = sub | cin;
  // carry into the MSB is re-timed to line up with cout for the overflow XOR
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_v, r_cm} <= '0;
    else begin
      r_v  <= {r_v[LAT-2:0], in_valid};
      r_cm <= {r_cm[0], w_c[WIDTH-1]};
    end
  assign out_valid = r_v[LAT-1];
  assign cout      = w_c[WIDTH];
  assign ovf       = r_cm[1] ^ w_c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_a, w_bs, w_s;
    if (i == 0) begin : g_noskew
      assign w_a  = a[i];
      assign w_bs = w_b[i];
    end else begin : g_skew
      logic [2*i-1:0] r_a, r_bs;
      always_ff @(posedge clk or posedge rst)
        if (rst) {r_a, r_bs} <= '0;
        else begin
          r_a  <= {r_a[2*i-2:0], a[i]};
          r_bs <= {r_bs[2*i-2:0], w_b[i]};
        end
      assign w_a  = r_a[2*i-1];
      assign w_bs = r_bs[2*i-1];
    end
    fa_pipe_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .a     (w_a),
      .b     (w_bs),
      .c_in  (w_c[i]),
      .s     (w_s),
      .c_out (w_c[i+1])
    );
    if (i == WIDTH - 1) begin : g_nodeskew
      assign sum[i] = w_s;
    end else begin : g_deskew
      localparam int D = 2 * (WIDTH - 1 - i);
      logic [D-1:0] r_s;
      always_ff @(posedge clk or posedge rst)
        if (rst) r_s <= '0;
        else r_s <= {r_s[D-2:0], w_s};
      assign sum[i] = r_s[D-1];
    end
  end
endmodule
